// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter: takes a WIDTH-bit word on a valid/ready handshake.
// It then drives the word one bit at a time on SER_OUT, each bit held TICKS_PER_BIT cycles.
// Latency: first bit appears on the accept edge. DONE pulses for the cycle after the last bit.
// Backpressure: LOAD_READY is low for the whole frame, and LOAD_VALID is ignored while busy.
module piso_serializer #(
  parameter int WIDTH         = 4,
  parameter int TICKS_PER_BIT = 1,
  parameter bit MSB_FIRST     = 1'b1,
  parameter bit IDLE_LEVEL    = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LOAD_VALID,
  output logic             LOAD_READY,
  input  logic [WIDTH-1:0] DATA_IN,
  output logic             SER_OUT,
  output logic             BUSY,
  output logic             DONE
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int TW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [BW-1:0]    r_bit_cnt;
  logic [BW-1:0]    w_bit_cnt_nxt;
  logic [TW-1:0]    r_tick_cnt;
  logic [TW-1:0]    w_tick_cnt_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             w_head_bit;

  // State, shift register, counters and the DONE flop all reset asynchronously
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_tick_cnt <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_tick_cnt <= w_tick_cnt_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // Next-state logic: accept in IDLE, then step ticks and bits until the last bit period ends
  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_tick_cnt_nxt = r_tick_cnt;
    w_done_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        // LOAD_READY is high throughout IDLE, so LOAD_VALID alone completes the handshake
        if (LOAD_VALID) begin
          w_shift_nxt    = DATA_IN;
          w_bit_cnt_nxt  = '0;
          w_tick_cnt_nxt = '0;
          w_state_nxt    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_tick_cnt == TICK_LAST) begin
          w_tick_cnt_nxt = '0;
          w_shift_nxt    = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
          if (r_bit_cnt == BIT_LAST) begin
            w_bit_cnt_nxt = '0;
            w_state_nxt   = S_IDLE;
            w_done_nxt    = 1'b1;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + BW'(1);
          end
        end else begin
          w_tick_cnt_nxt = r_tick_cnt + TW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // The bit on the wire is always the head of the shift register, whichever end leads
  assign w_head_bit = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];

  // Outputs decode only registered state, so reset reaches them without waiting for a clock
  assign LOAD_READY = (r_state == S_IDLE);
  assign BUSY       = (r_state == S_SHIFT);
  assign SER_OUT    = (r_state == S_SHIFT) ? w_head_bit : IDLE_LEVEL;
  assign DONE       = r_done;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: three instances (defaults, LSB-first, 3 ticks/bit).
// Expected serial bits are queued when a word is driven, then popped once per output cycle.
// Inputs are driven and outputs sampled on the falling edge, away from the active edge.
module tb_piso_serializer;

  logic       CLK;
  logic       RST;
  logic [2:0] vld;
  logic [3:0] din [3];

  wire ser_a, rdy_a, busy_a, done_a;
  wire ser_b, rdy_b, busy_b, done_b;
  wire ser_c, rdy_c, busy_c, done_c;

  wire [2:0] ser  = {ser_c, ser_b, ser_a};
  wire [2:0] rdy  = {rdy_c, rdy_b, rdy_a};
  wire [2:0] busy = {busy_c, busy_b, busy_a};
  wire [2:0] done = {done_c, done_b, done_a};

  int total = 0;
  int bad   = 0;
  bit exp_q[$];

  piso_serializer #(.WIDTH(4), .TICKS_PER_BIT(1), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_a (
    .CLK(CLK), .RST(RST), .LOAD_VALID(vld[0]), .LOAD_READY(rdy_a), .DATA_IN(din[0]),
    .SER_OUT(ser_a), .BUSY(busy_a), .DONE(done_a));

  piso_serializer #(.WIDTH(4), .TICKS_PER_BIT(1), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_b (
    .CLK(CLK), .RST(RST), .LOAD_VALID(vld[1]), .LOAD_READY(rdy_b), .DATA_IN(din[1]),
    .SER_OUT(ser_b), .BUSY(busy_b), .DONE(done_b));

  piso_serializer #(.WIDTH(4), .TICKS_PER_BIT(3), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_c (
    .CLK(CLK), .RST(RST), .LOAD_VALID(vld[2]), .LOAD_READY(rdy_c), .DATA_IN(din[2]),
    .SER_OUT(ser_c), .BUSY(busy_c), .DONE(done_c));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One complete frame on instance s, with optional LOAD_VALID/DATA_IN noise mid-frame
  task automatic run_frame(input int s, input logic [3:0] data, input int ticks,
                           input bit msb, input bit disturb, input string tag);
    int n;
    bit e;
    for (int k = 0; k < 4; k++) begin
      for (int t = 0; t < ticks; t++) exp_q.push_back(data[msb ? 3 - k : k]);
    end
    @(negedge CLK);
    chk({tag, "_rdy_pre"}, rdy[s], 1'b1);
    vld[s] = 1'b1;
    din[s] = data;
    @(negedge CLK);
    vld[s] = 1'b0;
    din[s] = ~data;
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk($sformatf("%s_ser%0d", tag, n), ser[s], e);
      chk($sformatf("%s_busy%0d", tag, n), busy[s], 1'b1);
      chk($sformatf("%s_rdy%0d", tag, n), rdy[s], 1'b0);
      chk($sformatf("%s_done%0d", tag, n), done[s], 1'b0);
      if (disturb && n == 1) begin
        vld[s] = 1'b1;
        din[s] = 4'b0100;
      end
      if (disturb && n == 2) vld[s] = 1'b0;
      n++;
      @(negedge CLK);
    end
    chk({tag, "_done"}, done[s], 1'b1);
    chk({tag, "_done_ser"}, ser[s], 1'b0);
    chk({tag, "_done_rdy"}, rdy[s], 1'b1);
    chk({tag, "_done_busy"}, busy[s], 1'b0);
    @(negedge CLK);
    chk({tag, "_after_done"}, done[s], 1'b0);
    chk({tag, "_after_busy"}, busy[s], 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    vld = 3'b000;
    for (int i = 0; i < 3; i++) din[i] = 4'b0000;
    repeat (2) @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_rdy%0d", i), rdy[i], 1'b1);
      chk($sformatf("rst_busy%0d", i), busy[i], 1'b0);
      chk($sformatf("rst_done%0d", i), done[i], 1'b0);
      chk($sformatf("rst_ser%0d", i), ser[i], 1'b0);
    end
    RST = 1'b0;
    @(negedge CLK);

    // 1: defaults, MSB first
    run_frame(0, 4'b1011, 1, 1'b1, 1'b0, "t1");
    // 2: LSB first
    run_frame(1, 4'b1011, 1, 1'b0, 1'b0, "t2");
    // 3: three ticks per bit
    run_frame(2, 4'b0110, 3, 1'b1, 1'b0, "t3");
    // 4: load attempt during a frame is ignored
    run_frame(0, 4'b1011, 1, 1'b1, 1'b1, "t4");
    repeat (2) begin
      @(negedge CLK);
      chk("t4_no_second_busy", busy[0], 1'b0);
      chk("t4_no_second_done", done[0], 1'b0);
    end

    // 5: LOAD_VALID held high gives frames separated by one idle/DONE cycle
    vld[0] = 1'b1;
    din[0] = 4'b1001;
    @(negedge CLK);
    for (int f = 0; f < 3; f++) begin
      exp_q.push_back(1'b1);
      exp_q.push_back(1'b0);
      exp_q.push_back(1'b0);
      exp_q.push_back(1'b1);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("t5_f%0d_ser%0d", f, k), ser[0], exp_q.pop_front());
        chk($sformatf("t5_f%0d_rdy%0d", f, k), rdy[0], 1'b0);
        @(negedge CLK);
      end
      chk($sformatf("t5_f%0d_done", f), done[0], 1'b1);
      chk($sformatf("t5_f%0d_idle_ser", f), ser[0], 1'b0);
      chk($sformatf("t5_f%0d_idle_rdy", f), rdy[0], 1'b1);
      if (f == 2) vld[0] = 1'b0;
      @(negedge CLK);
    end
    chk("t5_stopped", busy[0], 1'b0);

    // 6: asynchronous reset in the middle of bit 2
    @(negedge CLK);
    vld[0] = 1'b1;
    din[0] = 4'b1011;
    @(negedge CLK);
    vld[0] = 1'b0;
    chk("t6_bit0", ser[0], 1'b1);
    @(negedge CLK);
    chk("t6_bit1", ser[0], 1'b0);
    @(posedge CLK);
    #2;
    chk("t6_bit2_pre", ser[0], 1'b1);
    RST = 1'b1;
    #1;
    chk("t6_rst_ser", ser[0], 1'b0);
    chk("t6_rst_busy", busy[0], 1'b0);
    chk("t6_rst_rdy", rdy[0], 1'b1);
    chk("t6_rst_done", done[0], 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      chk("t6_no_done", done[0], 1'b0);
      chk("t6_idle_busy", busy[0], 1'b0);
    end
    run_frame(0, 4'b1111, 1, 1'b1, 1'b0, "t6_post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
